// File: rtl/memory_control_mp_if.sv
// memory_control_mp_if: cache/RAM-facing bundle of the multi-core memory controller, plus the RAM state type.
// Latency: none (wires only).
// Backpressure: carried by iwait/dwait/ccwait toward the caches and by ramstate from the RAM.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

interface memory_control_mp_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;

  logic [CPUS-1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       iwait, dwait, ccwait, ccinv;
  logic [CPUS-1:0][31:0] iload, dload, ccsnoopaddr;
  ramstate_t             ramstate;
  logic [31:0]           ramload, ramaddr, ramstore;
  logic                  ramREN, ramWEN;

  // controller side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramstate, ramload,
    output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramaddr, ramstore, ramREN, ramWEN
  );

  // caches + RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramstate, ramload,
    input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramaddr, ramstore, ramREN, ramWEN
  );
endinterface

// File: rtl/memory_control_mp.sv
// memory_control_mp: one RAM port shared by CPUS cores (I + D each), round-robin arbitration, MSI snoop bus.
// Latency: grant registered in IDLE; RAM access starts next cycle (coherence adds one SNOOP cycle).
// Backpressure: busy states stall until ramstate==ACCESS; FREE/BUSY/ERROR hold, ERROR retries the same word.
module memory_control_mp #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input logic CLK,
  input logic nRST,
  memory_control_mp_if.slave io_mem
);
  import cpu_types_pkg::*;

  localparam int IW = $clog2(CPUS);
  localparam int CW = $clog2(BLOCK_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, INSTR, WB, SNOOP, C2C, RAMRD} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_gnt, r_sup, r_dptr, r_iptr;
  logic [IW-1:0]   w_dwin, w_iwin, w_sup, w_didx, w_iidx;
  logic [IW:0]     w_dsum, w_isum;
  logic            w_dfound, w_ifound, w_supfound;
  logic [CPUS-1:0] w_dcand;
  logic            w_access, w_last;

  // a writeback (dWEN without cctrans) and a coherence request are both data candidates
  assign w_dcand  = io_mem.dWEN | io_mem.cctrans;
  assign w_access = (io_mem.ramstate == ACCESS);
  assign w_last   = (r_cnt == LAST);

  // round-robin picks: first candidate strictly after each pointer, wrapping; also the lowest dirty supplier
  always_comb begin
    w_dfound   = 1'b0;
    w_ifound   = 1'b0;
    w_supfound = 1'b0;
    w_dwin     = '0;
    w_iwin     = '0;
    w_sup      = '0;
    w_dsum     = '0;
    w_isum     = '0;
    w_didx     = '0;
    w_iidx     = '0;
    for (int i = 1; i <= CPUS; i++) begin
      w_dsum = {1'b0, r_dptr} + (IW+1)'(i);
      w_isum = {1'b0, r_iptr} + (IW+1)'(i);
      if (w_dsum >= (IW+1)'(CPUS)) w_dsum = w_dsum - (IW+1)'(CPUS);
      if (w_isum >= (IW+1)'(CPUS)) w_isum = w_isum - (IW+1)'(CPUS);
      w_didx = w_dsum[IW-1:0];
      w_iidx = w_isum[IW-1:0];
      if (!w_dfound && w_dcand[w_didx]) begin
        w_dfound = 1'b1;
        w_dwin   = w_didx;
      end
      if (!w_ifound && io_mem.iREN[w_iidx]) begin
        w_ifound = 1'b1;
        w_iwin   = w_iidx;
      end
    end
    for (int k = 0; k < CPUS; k++) begin
      if (!w_supfound && (IW'(k) != r_gnt) && io_mem.ccwrite[k] && io_mem.dWEN[k]) begin
        w_supfound = 1'b1;
        w_sup      = IW'(k);
      end
    end
  end

  // state register plus grant, supplier, word counter and round-robin pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sup   <= '0;
      r_dptr  <= IW'(CPUS - 1);
      r_iptr  <= IW'(CPUS - 1);
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_dfound) begin
            r_gnt  <= w_dwin;
            r_dptr <= w_dwin;
          end else if (w_ifound) begin
            r_gnt  <= w_iwin;
            r_iptr <= w_iwin;
          end
        end
        SNOOP: r_sup <= w_sup;
        WB, C2C, RAMRD: begin
          if (w_access) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // next-state: data beats instruction in IDLE; block transfers leave after the last word
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dfound)
          w_next = (io_mem.dWEN[w_dwin] && !io_mem.cctrans[w_dwin]) ? WB : SNOOP;
        else if (w_ifound)
          w_next = INSTR;
      end
      INSTR:          if (w_access) w_next = IDLE;
      WB, C2C, RAMRD: if (w_access && w_last) w_next = IDLE;
      SNOOP: begin
        if (!io_mem.dREN[r_gnt])  w_next = IDLE;
        else if (w_supfound)      w_next = C2C;
        else                      w_next = RAMRD;
      end
      default: w_next = IDLE;
    endcase
  end

  // outputs: everything idle unless the current state drives it for the granted core
  always_comb begin
    io_mem.iwait       = '1;
    io_mem.dwait       = '1;
    io_mem.iload       = '0;
    io_mem.dload       = '0;
    io_mem.ccwait      = '0;
    io_mem.ccinv       = '0;
    io_mem.ccsnoopaddr = '0;
    io_mem.ramaddr     = '0;
    io_mem.ramstore    = '0;
    io_mem.ramREN      = 1'b0;
    io_mem.ramWEN      = 1'b0;
    case (r_state)
      INSTR: begin
        io_mem.ramaddr = io_mem.iaddr[r_gnt];
        io_mem.ramREN  = 1'b1;
        if (w_access) begin
          io_mem.iwait[r_gnt] = 1'b0;
          io_mem.iload[r_gnt] = io_mem.ramload;
        end
      end
      WB: begin
        io_mem.ramaddr  = io_mem.daddr[r_gnt];
        io_mem.ramstore = io_mem.dstore[r_gnt];
        io_mem.ramWEN   = 1'b1;
        if (w_access) io_mem.dwait[r_gnt] = 1'b0;
      end
      SNOOP, C2C: begin
        for (int k = 0; k < CPUS; k++) begin
          if (IW'(k) != r_gnt) begin
            io_mem.ccwait[k]      = 1'b1;
            io_mem.ccsnoopaddr[k] = io_mem.daddr[r_gnt];
            io_mem.ccinv[k]       = io_mem.ccwrite[r_gnt];
          end
        end
        if (r_state == SNOOP) begin
          // upgrade: the requester already holds the data, only the invalidation was needed
          if (!io_mem.dREN[r_gnt]) io_mem.dwait[r_gnt] = 1'b0;
        end else begin
          // supplier's word goes to the requester and to RAM in the same beat
          io_mem.ramaddr      = io_mem.daddr[r_sup];
          io_mem.ramstore     = io_mem.dstore[r_sup];
          io_mem.ramWEN       = 1'b1;
          io_mem.dload[r_gnt] = io_mem.dstore[r_sup];
          if (w_access) begin
            io_mem.dwait[r_gnt] = 1'b0;
            io_mem.dwait[r_sup] = 1'b0;
          end
        end
      end
      RAMRD: begin
        for (int k = 0; k < CPUS; k++) begin
          if (IW'(k) != r_gnt) io_mem.ccwait[k] = 1'b1;
        end
        io_mem.ramaddr      = io_mem.daddr[r_gnt];
        io_mem.ramREN       = 1'b1;
        io_mem.dload[r_gnt] = io_mem.ramload;
        if (w_access) io_mem.dwait[r_gnt] = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_memory_control_mp.sv
// tb_memory_control_mp: directed vectors for a 2-core, 2-word-block memory controller.
// Latency: each table row is one clock; outputs sampled 2 time units after the rising edge.
// Backpressure: ramstate is driven per row to exercise BUSY/ERROR stalls.
module tb_memory_control_mp;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  memory_control_mp_if #(.CPUS(2)) bus ();

  memory_control_mp #(.CPUS(2), .BLOCK_WORDS(2)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .io_mem (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  iw, dw, ccw, cci;
    logic        ren, wen;
    logic [31:0] raddr, rstore, il1, il0, dl1, dl0;
  } out_t;

  typedef struct {
    logic [1:0]  iren, dren, dwen, cct, ccwr;
    ramstate_t   rs;
    logic [31:0] rload;
    out_t        x;
  } vec_t;

  int   total;
  int   bad;
  vec_t tbl[15];
  out_t idle_o;

  function automatic out_t mko(input logic [1:0] iw, dw, ccw, cci, input logic ren, wen,
                               input logic [31:0] raddr, rstore, il1, il0, dl1, dl0);
    out_t o;
    o.iw = iw; o.dw = dw; o.ccw = ccw; o.cci = cci; o.ren = ren; o.wen = wen;
    o.raddr = raddr; o.rstore = rstore; o.il1 = il1; o.il0 = il0; o.dl1 = dl1; o.dl0 = dl0;
    return o;
  endfunction

  function automatic vec_t mv(input logic [1:0] iren, dren, dwen, cct, ccwr, input ramstate_t rs,
                              input logic [31:0] rload, input out_t x);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.cct = cct; v.ccwr = ccwr;
    v.rs = rs; v.rload = rload; v.x = x;
    return v;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.iw = bus.iwait; o.dw = bus.dwait; o.ccw = bus.ccwait; o.cci = bus.ccinv;
    o.ren = bus.ramREN; o.wen = bus.ramWEN; o.raddr = bus.ramaddr; o.rstore = bus.ramstore;
    o.il1 = bus.iload[1]; o.il0 = bus.iload[0]; o.dl1 = bus.dload[1]; o.dl0 = bus.dload[0];
    return o;
  endfunction

  task automatic chk(input string name, input logic [201:0] act, input logic [201:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00; bus.cctrans = 2'b00; bus.ccwrite = 2'b00;
    bus.iaddr[0] = 32'h100; bus.iaddr[1] = 32'h180;
    bus.daddr[0] = 32'h200; bus.daddr[1] = 32'h300;
    bus.dstore[0] = 32'hA0; bus.dstore[1] = 32'hB1;
    bus.ramstate = FREE; bus.ramload = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    bus.iREN = v.iren; bus.dREN = v.dren; bus.dWEN = v.dwen; bus.cctrans = v.cct; bus.ccwrite = v.ccwr;
    bus.ramstate = v.rs; bus.ramload = v.rload;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  initial begin
    int pulses;
    int win;
    logic [1:0]  exp_dw;
    logic [63:0] exp_dl;
    total = 0;
    bad   = 0;
    idle_o = mko(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // instruction fetch with 2 BUSY cycles, upgrade snoop, writeback racing a fetch (with an ERROR retry)
    tbl[0]  = mv(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0, idle_o);
    tbl[1]  = mv(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, BUSY,   32'h0,
                 mko(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl[2]  = tbl[1];
    tbl[3]  = mv(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'hDEADBEEF,
                 mko(2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0));
    tbl[4]  = mv(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0, idle_o);
    tbl[5]  = mv(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, FREE,   32'h0, idle_o);
    tbl[6]  = mv(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, FREE,   32'h0,
                 mko(2'b11, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl[7]  = mv(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0, idle_o);
    tbl[8]  = mv(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, FREE,   32'h0, idle_o);
    tbl[9]  = mv(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, ACCESS, 32'h0,
                 mko(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h200, 32'hA0, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl[10] = mv(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, ERROR,  32'h0,
                 mko(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h200, 32'hA0, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl[11] = tbl[9];
    tbl[12] = mv(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0, idle_o);
    tbl[13] = mv(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'h12345678,
                 mko(2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h180, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0));
    tbl[14] = mv(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0, idle_o);

    clear_inputs();
    nRST = 1'b0;
    #12;
    chk("reset_outputs", 202'(observe()), 202'(idle_o));
    @(negedge CLK);
    nRST = 1'b1;
    step();
    for (int n = 0; n < 15; n++) begin
      apply(tbl[n]);
      #1;
      chk($sformatf("vec%0d", n), 202'(observe()), 202'(tbl[n].x));
      step();
    end

    // both cores hold a read-miss coherence request: grants must alternate 0,1,0,1 with two words each
    do_reset();
    bus.dREN = 2'b11; bus.cctrans = 2'b11; bus.ramstate = ACCESS; bus.ramload = 32'h5A5A0001;
    pulses = 0;
    for (int c = 0; c < 200 && pulses < 16; c++) begin
      #1;
      if (bus.ramREN && bus.dwait != 2'b11) begin
        win    = (pulses / 2) % 2;
        exp_dw = (win == 1) ? 2'b01 : 2'b10;
        exp_dl = (win == 1) ? {32'h5A5A0001, 32'h0} : {32'h0, 32'h5A5A0001};
        chk($sformatf("rr_dwait%0d", pulses), 202'(bus.dwait), 202'(exp_dw));
        chk($sformatf("rr_dload%0d", pulses), 202'({bus.dload[1], bus.dload[0]}), 202'(exp_dl));
        pulses++;
      end
      step();
    end
    chk("rr_pulse_count", 202'(pulses), 202'(16));

    // cache-to-cache: core0 wants to modify 0x200, core1 holds it dirty and supplies 0x11, 0x22
    do_reset();
    bus.daddr[0] = 32'h200; bus.daddr[1] = 32'h200; bus.dstore[1] = 32'h11;
    bus.cctrans = 2'b01; bus.dREN = 2'b01; bus.ccwrite = 2'b11; bus.dWEN = 2'b10; bus.ramstate = ACCESS;
    #1;
    chk("c2c_idle", 202'({bus.ramREN, bus.ramWEN, bus.ccwait}), 202'(4'b0000));
    step();
    #1;
    chk("c2c_snoop", 202'({bus.ccwait, bus.ccinv, bus.ramREN, bus.ramWEN, bus.ccsnoopaddr[1]}),
        202'({2'b10, 2'b10, 1'b0, 1'b0, 32'h200}));
    step();
    for (int w = 0; w < 2; w++) begin
      #1;
      chk($sformatf("c2c_word%0d", w),
          202'({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dload[0], bus.dwait, bus.ccinv}),
          202'({1'b1, 1'b0, 32'h200 + 32'(4 * w), (w == 0) ? 32'h11 : 32'h22,
                (w == 0) ? 32'h11 : 32'h22, 2'b00, 2'b10}));
      step();
      bus.daddr[0] = bus.daddr[0] + 32'h4;
      bus.daddr[1] = bus.daddr[1] + 32'h4;
      bus.dstore[1] = 32'h22;
    end
    clear_inputs();
    #1;
    chk("c2c_done", 202'({bus.ccwait, bus.ccinv, bus.ramWEN, bus.dwait}), 202'({2'b00, 2'b00, 1'b0, 2'b11}));

    // reset asserted while a RAM block read is stalled
    do_reset();
    bus.daddr[0] = 32'h400; bus.cctrans = 2'b01; bus.dREN = 2'b01; bus.ramstate = BUSY; bus.ramload = 32'h77;
    step();
    step();
    #1;
    chk("rd_active", 202'({bus.ramREN, bus.ramaddr, bus.dload[0], bus.ccwait}),
        202'({1'b1, 32'h400, 32'h77, 2'b10}));
    nRST = 1'b0;
    #1;
    chk("rst_mid_rd", 202'(observe()), 202'(idle_o));
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    #1;
    chk("rst_after", 202'(observe()), 202'(idle_o));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
